// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: resolves forwarding or hazard stalls and hands signed operands downstream.
// Define EX_OPERAND_FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise RAW hazards stall the input.
module ex_operand_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         rs1_addr,
    input  logic [4:0]         rs2_addr,
    input  logic [4:0]         rd_addr,
    input  logic [63:0]        rs1_data,
    input  logic [63:0]        rs2_data,
    input  logic [63:0]        imm,
    input  logic               use_imm,
    input  logic [3:0]         alu_op,
    input  logic               exm_valid,
    input  logic               exm_wen,
    input  logic [4:0]         exm_rd,
    input  logic [63:0]        exm_result,
    input  logic               mwb_valid,
    input  logic               mwb_wen,
    input  logic [4:0]         mwb_rd,
    input  logic [63:0]        mwb_result,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [63:0] out_a,
    output logic signed [63:0] out_b,
    output logic [4:0]         out_rd,
    output logic [3:0]         out_op,
    output logic               hazard_stall,
    output logic [15:0]        stall_cycles
);

    // x0 is hardwired to zero, so it never matches a pending writeback
    function automatic logic wb_match(input logic v, input logic w,
                                      input logic [4:0] rd, input logic [4:0] src);
        return v && w && (rd != 5'd0) && (rd == src);
    endfunction

    logic        rs1_exm_s;
    logic        rs1_mwb_s;
    logic        rs2_exm_s;
    logic        rs2_mwb_s;
    logic [63:0] opa_s;
    logic [63:0] opb_s;
    logic        hazard_s;
    logic        accept_s;

    assign rs1_exm_s = wb_match(exm_valid, exm_wen, exm_rd, rs1_addr);
    assign rs1_mwb_s = wb_match(mwb_valid, mwb_wen, mwb_rd, rs1_addr);
    assign rs2_exm_s = wb_match(exm_valid, exm_wen, exm_rd, rs2_addr);
    assign rs2_mwb_s = wb_match(mwb_valid, mwb_wen, mwb_rd, rs2_addr);

`ifdef EX_OPERAND_FORWARD_EN
    // Operand selection with EX/MEM taking priority over the older MEM/WB result
    always_comb begin
        opa_s    = rs1_data;
        opb_s    = rs2_data;
        hazard_s = 1'b0;
        if (rs1_exm_s) begin
            opa_s = exm_result;
        end else if (rs1_mwb_s) begin
            opa_s = mwb_result;
        end else begin
            opa_s = rs1_data;
        end
        if (use_imm) begin
            opb_s = imm;
        end else if (rs2_exm_s) begin
            opb_s = exm_result;
        end else if (rs2_mwb_s) begin
            opb_s = mwb_result;
        end else begin
            opb_s = rs2_data;
        end
    end
`else
    // Register-file operands only; any pending write to a used source holds the input
    always_comb begin
        opa_s    = rs1_data;
        opb_s    = rs2_data;
        hazard_s = 1'b0;
        if (use_imm) begin
            opb_s    = imm;
            hazard_s = in_valid && (rs1_exm_s || rs1_mwb_s);
        end else begin
            opb_s    = rs2_data;
            hazard_s = in_valid && (rs1_exm_s || rs1_mwb_s || rs2_exm_s || rs2_mwb_s);
        end
    end
`endif

    assign hazard_stall = hazard_s;
    assign in_ready     = (!out_valid || out_ready) && !hazard_s && !flush;
    assign accept_s     = in_valid && in_ready;

    // Output register: reset, then flush, then capture, then drain on downstream ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= 64'sd0;
            out_b     <= 64'sd0;
            out_rd    <= 5'd0;
            out_op    <= 4'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_a     <= opa_s;
            out_b     <= opb_s;
            out_rd    <= rd_addr;
            out_op    <= alu_op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Saturating count of cycles where upstream offered data but was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (in_valid && !in_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

endmodule
